index_decoder64_bitmap: RTL and testbench

- Streaming index-to-one-hot decoder. It is the write side of the team's 64-way priority encoder.
- Accepts 6-bit indices with an opcode over a valid/ready handshake. Each accepted command is decoded to a 64-bit one-hot vector and applied to a persistent 64-bit bitmap register (set / clear / toggle / decode-only).
- One registered output stage presents the one-hot vector, the updated bitmap and its population count.
- The bitmap output feeds the priority encoder that selects the highest pending index.

---
 rtl/prio_pkg.sv | 28 ++
 rtl/popcount64.sv | 17 +
 rtl/index_decoder64_bitmap.sv | 114 +++++++++++
 tb/tb_index_decoder64_bitmap.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared definitions for the 64-way bitmap decoder and the priority encoder
// that consumes its bitmap.
package prio_pkg;

  localparam int IDX_W = 6;
  localparam int VEC_W = 64;
  localparam int CNT_W = 7;

  typedef logic [VEC_W-1:0] vec64_t;

  typedef enum logic [1:0] {
    OP_DECODE = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  // Mask of the index positions that may ever be set in the bitmap.
  function automatic vec64_t valid_mask(input int n_idx);
    vec64_t m;
    m = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (i < n_idx) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit vector (result 0..64).
module popcount64
  import prio_pkg::*;
(
  input  vec64_t           vec_i,
  output logic [CNT_W-1:0] count_o
);

  // Sum the set bits one at a time; synthesis builds an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < VEC_W; i++) begin
      count_o = count_o + {{(CNT_W-1){1'b0}}, vec_i[i]};
    end
  end

endmodule

// File: rtl/index_decoder64_bitmap.sv
// Streaming index-to-one-hot decoder with a persistent 64-bit bitmap.
// Handshake: a command transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. in_ready is
// !out_valid || out_ready (no skid buffer), and all out_* hold while stalled.
module index_decoder64_bitmap
  import prio_pkg::*;
#(
  parameter int N_IDX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output vec64_t           out_onehot,
  output vec64_t           out_bitmap,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output vec64_t           bitmap
);

  localparam vec64_t VALID_MASK = valid_mask(N_IDX);

  vec64_t           bitmap_q, bitmap_d;
  logic             out_valid_q, out_valid_d;
  vec64_t           out_onehot_q, out_onehot_d;
  vec64_t           out_bitmap_q, out_bitmap_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             idx_ok;
  vec64_t           onehot;
  vec64_t           base;
  vec64_t           op_result;
  logic [CNT_W-1:0] next_count;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode the index; out-of-range indices produce an empty one-hot.
  always_comb begin
    idx_ok = (int'(in_idx) < N_IDX);
    onehot = idx_ok ? (vec64_t'(1) << in_idx) : '0;
  end

  // Apply clr first, then the accepted op; bits beyond N_IDX are forced to 0.
  always_comb begin
    base      = clr ? '0 : bitmap_q;
    op_result = base;
    case (op_e'(in_op))
      OP_DECODE: op_result = base;
      OP_SET:    op_result = base | onehot;
      OP_CLEAR:  op_result = base & ~onehot;
      OP_TOGGLE: op_result = base ^ onehot;
      default:   op_result = base;
    endcase
    bitmap_d = (accept ? op_result : base) & VALID_MASK;
  end

  popcount64 u_popcount (
    .vec_i   (bitmap_d),
    .count_o (next_count)
  );

  // Output stage next state: load on accept, drop valid on drain, else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    out_bitmap_d = out_bitmap_q;
    out_count_d  = out_count_q;
    out_err_d    = out_err_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_onehot_d = onehot;
      out_bitmap_d = bitmap_d;
      out_count_d  = next_count;
      out_err_d    = !idx_ok;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Bitmap and output-stage registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q     <= '0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_bitmap_q <= '0;
      out_count_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_bitmap_q <= out_bitmap_d;
      out_count_q  <= out_count_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_bitmap = out_bitmap_q;
  assign out_count  = out_count_q;
  assign out_err    = out_err_q;
  assign bitmap     = bitmap_q;

endmodule

// File: tb/tb_index_decoder64_bitmap.sv
// Directed bench for index_decoder64_bitmap: a 64-index instance and a
// 40-index instance share the same stimulus.
module tb_index_decoder64_bitmap;
  import prio_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic [1:0]       in_op = 2'b00;
  logic [IDX_W-1:0] in_idx = '0;
  logic             clr = 1'b0;
  logic             out_ready = 1'b1;

  logic             in_ready, out_valid, out_err;
  vec64_t           out_onehot, out_bitmap, bitmap;
  logic [CNT_W-1:0] out_count;

  logic             in_ready40, out_valid40, out_err40;
  vec64_t           out_onehot40, out_bitmap40, bitmap40;
  logic [CNT_W-1:0] out_count40;

  index_decoder64_bitmap #(.N_IDX(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_idx(in_idx), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_onehot(out_onehot), .out_bitmap(out_bitmap),
    .out_count(out_count), .out_err(out_err), .bitmap(bitmap)
  );

  index_decoder64_bitmap #(.N_IDX(40)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready40),
    .in_op(in_op), .in_idx(in_idx), .clr(clr), .out_valid(out_valid40),
    .out_ready(out_ready), .out_onehot(out_onehot40), .out_bitmap(out_bitmap40),
    .out_count(out_count40), .out_err(out_err40), .bitmap(bitmap40)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs and samples both sit 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input int idx);
    in_valid = 1'b1;
    in_op    = op;
    in_idx   = IDX_W'(idx);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    check("reset out_valid",  64'(out_valid), 64'd0);
    check("reset out_bitmap", out_bitmap, 64'd0);
    check("reset out_onehot", out_onehot, 64'd0);
    check("reset out_count",  64'(out_count), 64'd0);
    check("reset out_err",    64'(out_err), 64'd0);
    check("reset bitmap",     bitmap, 64'd0);
    check("reset in_ready",   64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Back-to-back SET 5, 63, 0
    drive(OP_SET, 5);
    step();
    check("set5 onehot", out_onehot, 64'h0000_0000_0000_0020);
    check("set5 valid",  64'(out_valid), 64'd1);
    check("set5 bitmap live", bitmap, 64'h0000_0000_0000_0020);
    drive(OP_SET, 63);
    step();
    check("set63 onehot", out_onehot, 64'h8000_0000_0000_0000);
    check("n40 set63 err", 64'(out_err40), 64'd1);
    check("n40 set63 onehot", out_onehot40, 64'd0);
    drive(OP_SET, 0);
    step();
    check("set0 onehot", out_onehot, 64'h0000_0000_0000_0001);
    check("set0 out_bitmap", out_bitmap, 64'h8000_0000_0000_0021);
    check("set0 count", 64'(out_count), 64'd3);
    idle();
    step();
    check("drain valid", 64'(out_valid), 64'd0);
    check("drain out_bitmap held", out_bitmap, 64'h8000_0000_0000_0021);

    // Backpressure
    out_ready = 1'b0;
    drive(OP_SET, 10);
    step();
    check("bp set10 onehot", out_onehot, 64'h0000_0000_0000_0400);
    drive(OP_SET, 11);
    for (int i = 0; i < 4; i++) begin
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp onehot held", out_onehot, 64'h0000_0000_0000_0400);
      check("bp bitmap no set11", bitmap, 64'h8000_0000_0000_0421);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready release", 64'(in_ready), 64'd1);
    step();
    check("bp set11 onehot", out_onehot, 64'h0000_0000_0000_0800);
    check("bp set11 count", 64'(out_count), 64'd5);
    idle();
    step();

    // TOGGLE 7 twice, then CLEAR 7
    drive(OP_TOGGLE, 7);
    step();
    check("tog7a bitmap", out_bitmap, 64'h8000_0000_0000_0CA1);
    check("tog7a count", 64'(out_count), 64'd6);
    step();
    check("tog7b bitmap", out_bitmap, 64'h8000_0000_0000_0C21);
    check("tog7b count", 64'(out_count), 64'd5);
    drive(OP_CLEAR, 7);
    step();
    check("clr7 bitmap", out_bitmap, 64'h8000_0000_0000_0C21);
    check("clr7 count", 64'(out_count), 64'd5);
    check("clr7 err", 64'(out_err), 64'd0);
    idle();
    step();

    // Out-of-range index on the 40-position instance
    drive(OP_SET, 45);
    step();
    check("n40 set45 err", 64'(out_err40), 64'd1);
    check("n40 set45 onehot", out_onehot40, 64'd0);
    check("n40 set45 bitmap", out_bitmap40, 64'h0000_0000_0000_0C21);
    check("n64 set45 err", 64'(out_err), 64'd0);
    drive(OP_SET, 39);
    step();
    check("n40 set39 err", 64'(out_err40), 64'd0);
    check("n40 set39 onehot", out_onehot40, 64'h0000_0080_0000_0000);
    check("n40 set39 bitmap", out_bitmap40, 64'h0000_0080_0000_0C21);
    check("n64 set39 bitmap", out_bitmap, 64'h8000_2080_0000_0C21);
    check("n64 set39 count", 64'(out_count), 64'd7);
    idle();
    step();

    // clr alone: live bitmap clears, held outputs untouched
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr alone bitmap", bitmap, 64'd0);
    check("clr alone out_bitmap", out_bitmap, 64'h8000_2080_0000_0C21);
    check("clr alone count", 64'(out_count), 64'd7);
    check("clr alone valid", 64'(out_valid), 64'd0);

    // Fill 0xFF, then clr coincident with ops
    for (int i = 0; i < 8; i++) begin
      drive(OP_SET, i);
      step();
    end
    check("fill ff bitmap", out_bitmap, 64'h0000_0000_0000_00FF);
    check("fill ff count", 64'(out_count), 64'd8);
    clr = 1'b1;
    drive(OP_SET, 2);
    step();
    check("clr+set2 bitmap", bitmap, 64'h0000_0000_0000_0004);
    check("clr+set2 count", 64'(out_count), 64'd1);
    drive(OP_TOGGLE, 3);
    step();
    check("clr+tog3 bitmap", out_bitmap, 64'h0000_0000_0000_0008);
    drive(OP_CLEAR, 3);
    step();
    check("clr+clr3 bitmap", out_bitmap, 64'd0);
    check("clr+clr3 count", 64'(out_count), 64'd0);
    clr = 1'b0;
    idle();
    step();

    // Asynchronous reset while stalled
    out_ready = 1'b0;
    drive(OP_SET, 20);
    step();
    check("pre-rst valid", 64'(out_valid), 64'd1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 64'(out_valid), 64'd0);
    check("async rst onehot", out_onehot, 64'd0);
    check("async rst out_bitmap", out_bitmap, 64'd0);
    check("async rst count", 64'(out_count), 64'd0);
    check("async rst bitmap", bitmap, 64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    drive(OP_SET, 1);
    step();
    check("post-rst onehot", out_onehot, 64'h0000_0000_0000_0002);
    check("post-rst bitmap", out_bitmap, 64'h0000_0000_0000_0002);
    check("post-rst count", 64'(out_count), 64'd1);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
